// File: rtl/k054539_hostif.sv
// k054539_hostif
//   Host-side core of the 054539 PCM sound chip: CPU-visible channel and
//   control register banks, key-on/key-off channel status, and a byte port
//   through which the host reads and writes external sample RAM.
// Ports
//   CLK, RES               clock (rising edge), synchronous active-high reset
//   PIN_AB, PIN_AB09       host address; AB09 selects channel (0) / control (1) bank
//   PIN_DB_IN, PIN_DB_OUT  host write / read data (read data 0x00 while NCS high)
//   PIN_NCS/NRD/NWR        active-low host strobes, asynchronous to CLK
//   PIN_WAIT               active-low, low while a sample RAM port access runs
//   PIN_RA, PIN_RD_IN/OUT  sample RAM address, read data, write data
//   PIN_RACS/RAWP/RAOE     active-low RAM chip select, write pulse, output enable
module k054539_hostif #(
   parameter int NCH  = 8,
   parameter int RA_W = 24
) (
   input  logic            CLK,
   input  logic            RES,
   input  logic [7:0]      PIN_AB,
   input  logic            PIN_AB09,
   input  logic [7:0]      PIN_DB_IN,
   output logic [7:0]      PIN_DB_OUT,
   input  logic            PIN_NCS,
   input  logic            PIN_NRD,
   input  logic            PIN_NWR,
   output logic            PIN_WAIT,
   output logic [RA_W-1:0] PIN_RA,
   input  logic [7:0]      PIN_RD_IN,
   output logic [7:0]      PIN_RD_OUT,
   output logic            PIN_RACS,
   output logic            PIN_RAWP,
   output logic            PIN_RAOE
);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STB1, S_STB2, S_DONE} state_e;

   localparam logic [7:0] OFF_KON  = 8'h14;
   localparam logic [7:0] OFF_KOFF = 8'h15;
   localparam logic [7:0] OFF_P0   = 8'h28;
   localparam logic [7:0] OFF_P1   = 8'h29;
   localparam logic [7:0] OFF_P2   = 8'h2A;
   localparam logic [7:0] OFF_STAT = 8'h2C;
   localparam logic [7:0] OFF_PORT = 8'h2D;
   localparam logic [7:0] OFF_END  = 8'h30;

   logic [1:0]     ncs_q, nrd_q, nwr_q;
   logic           wr_prev_q, rd_prev_q;
   logic           wr_lvl, rd_lvl, wr_ev, rd_ev, wr_go, rd_go;

   logic [7:0]     chan_q [256];
   logic [7:0]     ctrl_q [48];

   state_e         state_q, state_d;
   logic [23:0]    ptr_q, ptr_d;
   logic [NCH-1:0] active_q, active_d;
   logic [7:0]     latch_q, latch_d;
   logic [7:0]     wdata_q, wdata_d;
   logic           is_wr_q, is_wr_d;
   logic [8:0]     rd_addr_q, rd_addr_d;

   logic           port_en, ctrl_wr_ok;
   logic [7:0]     act8, rdata;
   logic [23:0]    ra;

   // Strobe levels combine chip select with the read/write strobe; an event is
   // the first synchronized cycle the combination reads low.
   assign wr_lvl = ncs_q[1] | nwr_q[1];
   assign rd_lvl = ncs_q[1] | nrd_q[1];
   assign wr_ev  = wr_prev_q & ~wr_lvl;
   assign rd_ev  = rd_prev_q & ~rd_lvl;
   // Host events arriving while a RAM port access runs are dropped entirely.
   assign wr_go  = wr_ev & (state_q == S_IDLE);
   assign rd_go  = rd_ev & (state_q == S_IDLE);

   assign port_en = ctrl_q[47][4];
   assign act8    = 8'(active_q);

   assign ctrl_wr_ok = wr_go & PIN_AB09 & (PIN_AB < OFF_END) &
                       !(PIN_AB inside {OFF_KON, OFF_KOFF, OFF_P0, OFF_P1,
                                        OFF_P2, OFF_STAT, OFF_PORT});

   always_ff @(posedge CLK) begin
      if (RES) begin
         ncs_q     <= '1;
         nrd_q     <= '1;
         nwr_q     <= '1;
         wr_prev_q <= 1'b1;
         rd_prev_q <= 1'b1;
      end else begin
         ncs_q     <= {ncs_q[0], PIN_NCS};
         nrd_q     <= {nrd_q[0], PIN_NRD};
         nwr_q     <= {nwr_q[0], PIN_NWR};
         wr_prev_q <= wr_lvl;
         rd_prev_q <= rd_lvl;
      end
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         for (int unsigned i = 0; i < 256; i++) chan_q[i] <= '0;
         for (int unsigned i = 0; i < 48; i++)  ctrl_q[i] <= '0;
      end else begin
         if (wr_go && !PIN_AB09) chan_q[PIN_AB] <= PIN_DB_IN;
         if (ctrl_wr_ok)         ctrl_q[PIN_AB[5:0]] <= PIN_DB_IN;
      end
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         active_q  <= '0;
         latch_q   <= '0;
         wdata_q   <= '0;
         is_wr_q   <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         active_q  <= active_d;
         latch_q   <= latch_d;
         wdata_q   <= wdata_d;
         is_wr_q   <= is_wr_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      active_d   = active_q;
      latch_d    = latch_q;
      wdata_d    = wdata_q;
      is_wr_d    = is_wr_q;
      rd_addr_d  = rd_addr_q;
      ra         = '0;
      PIN_RD_OUT = '0;
      PIN_RACS   = 1'b1;
      PIN_RAWP   = 1'b1;
      PIN_RAOE   = 1'b1;
      PIN_WAIT   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            PIN_WAIT = 1'b1;
            if (wr_go && PIN_AB09) begin
               unique case (PIN_AB)
                  OFF_KON:  active_d = active_q | NCH'(PIN_DB_IN);
                  OFF_KOFF: active_d = active_q & ~NCH'(PIN_DB_IN);
                  OFF_P0:   ptr_d[7:0]   = PIN_DB_IN;
                  OFF_P1:   ptr_d[15:8]  = PIN_DB_IN;
                  OFF_P2:   ptr_d[23:16] = PIN_DB_IN;
                  OFF_PORT: if (port_en) begin
                     state_d = S_SETUP;
                     is_wr_d = 1'b1;
                     wdata_d = PIN_DB_IN;
                  end
                  default: ;
               endcase
            end
            if (rd_go) begin
               rd_addr_d = {PIN_AB09, PIN_AB};
               // A simultaneous port write already claimed the FSM.
               if (PIN_AB09 && PIN_AB == OFF_PORT && port_en && state_d == S_IDLE) begin
                  state_d = S_SETUP;
                  is_wr_d = 1'b0;
               end
            end
         end
         S_SETUP: begin
            state_d    = S_STB1;
            ra         = ptr_q;
            PIN_RD_OUT = is_wr_q ? wdata_q : '0;
            PIN_RACS   = 1'b0;
         end
         S_STB1, S_STB2: begin
            state_d    = (state_q == S_STB1) ? S_STB2 : S_DONE;
            ra         = ptr_q;
            PIN_RD_OUT = is_wr_q ? wdata_q : '0;
            PIN_RACS   = 1'b0;
            PIN_RAWP   = ~is_wr_q;
            PIN_RAOE   = is_wr_q;
            if (state_q == S_STB2 && !is_wr_q) latch_d = PIN_RD_IN;
         end
         S_DONE: begin
            state_d    = S_IDLE;
            ra         = ptr_q;
            PIN_RD_OUT = is_wr_q ? wdata_q : '0;
            ptr_d      = ptr_q + 24'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign PIN_RA = RA_W'(ra);

   always_comb begin
      rdata = '0;
      if (!rd_addr_q[8]) begin
         rdata = chan_q[rd_addr_q[7:0]];
      end else if (rd_addr_q[7:0] < OFF_END) begin
         unique case (rd_addr_q[7:0])
            OFF_KON, OFF_KOFF: rdata = '0;
            OFF_P0:   rdata = ptr_q[7:0];
            OFF_P1:   rdata = ptr_q[15:8];
            OFF_P2:   rdata = ptr_q[23:16];
            OFF_STAT: rdata = act8;
            OFF_PORT: rdata = latch_q;
            default:  rdata = ctrl_q[rd_addr_q[5:0]];
         endcase
      end
   end

   assign PIN_DB_OUT = PIN_NCS ? '0 : rdata;

endmodule

// File: tb/tb_k054539_hostif.sv
// tb_k054539_hostif
//   Scoreboarded bench for k054539_hostif: host accesses update a
//   behavioural register/RAM model, expected responses are queued, and a
//   monitor pops them when the DUT presents read data or RAM strobes.
module tb_k054539_hostif;

   logic        CLK = 1'b0;
   logic        RES;
   logic [7:0]  PIN_AB;
   logic        PIN_AB09;
   logic [7:0]  PIN_DB_IN;
   logic [7:0]  PIN_DB_OUT;
   logic        PIN_NCS, PIN_NRD, PIN_NWR;
   logic        PIN_WAIT;
   logic [23:0] PIN_RA;
   logic [7:0]  PIN_RD_IN;
   logic [7:0]  PIN_RD_OUT;
   logic        PIN_RACS, PIN_RAWP, PIN_RAOE;

   always #5 CLK = ~CLK;

   k054539_hostif #(.NCH(8), .RA_W(24)) dut (
      .CLK(CLK), .RES(RES), .PIN_AB(PIN_AB), .PIN_AB09(PIN_AB09),
      .PIN_DB_IN(PIN_DB_IN), .PIN_DB_OUT(PIN_DB_OUT), .PIN_NCS(PIN_NCS),
      .PIN_NRD(PIN_NRD), .PIN_NWR(PIN_NWR), .PIN_WAIT(PIN_WAIT),
      .PIN_RA(PIN_RA), .PIN_RD_IN(PIN_RD_IN), .PIN_RD_OUT(PIN_RD_OUT),
      .PIN_RACS(PIN_RACS), .PIN_RAWP(PIN_RAWP), .PIN_RAOE(PIN_RAOE)
   );

   // external sample RAM contents as a fixed function of address
   function automatic logic [7:0] ram_fn(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
   endfunction
   assign PIN_RD_IN = ram_fn(PIN_RA);

   // reference model
   logic [7:0]  m_chan [256];
   logic [7:0]  m_ctrl [48];
   logic [7:0]  m_act;
   logic [23:0] m_ptr;
   logic [7:0]  m_latch;

   logic [7:0]  q_rd [$];
   logic [31:0] q_wr [$];
   logic [23:0] q_rr [$];

   int checks = 0;
   int errors = 0;
   logic rd_valid = 1'b0;
   logic abort_exp = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 256; i++) m_chan[i] = 8'h00;
      for (int i = 0; i < 48; i++)  m_ctrl[i] = 8'h00;
      m_act = 8'h00; m_ptr = 24'h0; m_latch = 8'h00;
   endtask

   function automatic logic m_en();
      return m_ctrl[47][4];
   endfunction

   task automatic m_write(input logic [8:0] a, input logic [7:0] d);
      int off = int'(a[7:0]);
      if (!a[8]) m_chan[off] = d;
      else if (off < 48) begin
         case (off)
            'h14: m_act = m_act | d;
            'h15: m_act = m_act & ~d;
            'h28: m_ptr[7:0]   = d;
            'h29: m_ptr[15:8]  = d;
            'h2A: m_ptr[23:16] = d;
            'h2C: ;
            'h2D: if (m_en()) begin
               q_wr.push_back({m_ptr, d});
               m_ptr = m_ptr + 1;
            end
            default: m_ctrl[off] = d;
         endcase
      end
   endtask

   task automatic m_read(input logic [8:0] a, output logic [7:0] v);
      int off = int'(a[7:0]);
      v = 8'h00;
      if (!a[8]) v = m_chan[off];
      else if (off < 48) begin
         case (off)
            'h14, 'h15: v = 8'h00;
            'h28: v = m_ptr[7:0];
            'h29: v = m_ptr[15:8];
            'h2A: v = m_ptr[23:16];
            'h2C: v = m_act;
            'h2D: begin
               if (m_en()) begin
                  q_rr.push_back(m_ptr);
                  m_latch = ram_fn(m_ptr);
                  m_ptr = m_ptr + 1;
               end
               v = m_latch;
            end
            default: v = m_ctrl[off];
         endcase
      end
   endtask

   // monitor: pops expectations when the DUT produces read data or RAM strobes
   int          wp_len = 0, oe_len = 0;
   logic [23:0] wp_ra, oe_ra;
   logic [7:0]  wp_do;
   always @(negedge CLK) begin
      if (!PIN_RAWP) begin
         wp_len++; wp_ra = PIN_RA; wp_do = PIN_RD_OUT;
         check("racs_during_wr", {31'd0, PIN_RACS}, 32'd0);
      end else if (wp_len != 0) begin
         if (!abort_exp) begin
            if (q_wr.size() == 0) check("ramwr_unexpected", 32'd1, 32'd0);
            else begin
               logic [31:0] e;
               e = q_wr.pop_front();
               check("ramwr_addr", {8'd0, wp_ra}, {8'd0, e[31:8]});
               check("ramwr_data", {24'd0, wp_do}, {24'd0, e[7:0]});
               check("ramwr_len", wp_len, 2);
            end
         end
         wp_len = 0;
      end
      if (!PIN_RAOE) begin
         oe_len++; oe_ra = PIN_RA;
      end else if (oe_len != 0) begin
         if (q_rr.size() == 0) check("ramrd_unexpected", 32'd1, 32'd0);
         else begin
            logic [23:0] e;
            e = q_rr.pop_front();
            check("ramrd_addr", {8'd0, oe_ra}, {8'd0, e});
            check("ramrd_len", oe_len, 2);
         end
         oe_len = 0;
      end
      if (rd_valid) begin
         if (q_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
         else check("db_out", {24'd0, PIN_DB_OUT}, {24'd0, q_rd.pop_front()});
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!PIN_WAIT && n < 30) begin
         @(negedge CLK);
         n++;
      end
      check("wait_release", {31'd0, PIN_WAIT}, 32'd1);
   endtask

   task automatic host_write(input logic [8:0] a, input logic [7:0] d);
      @(negedge CLK);
      PIN_AB = a[7:0]; PIN_AB09 = a[8]; PIN_DB_IN = d;
      PIN_NCS = 1'b0; PIN_NWR = 1'b0;
      m_write(a, d);
      repeat (4) @(negedge CLK);
      wait_idle();
      PIN_NCS = 1'b1; PIN_NWR = 1'b1;
      repeat (3) @(negedge CLK);
   endtask

   task automatic host_read(input logic [8:0] a);
      logic [7:0] v;
      @(negedge CLK);
      PIN_AB = a[7:0]; PIN_AB09 = a[8];
      PIN_NCS = 1'b0; PIN_NRD = 1'b0;
      m_read(a, v);
      q_rd.push_back(v);
      repeat (4) @(negedge CLK);
      wait_idle();
      @(posedge CLK); rd_valid = 1'b1;
      @(posedge CLK); rd_valid = 1'b0;
      @(negedge CLK);
      PIN_NCS = 1'b1; PIN_NRD = 1'b1;
      repeat (3) @(negedge CLK);
   endtask

   task automatic set_ptr(input logic [23:0] p);
      host_write(9'h128, p[7:0]);
      host_write(9'h129, p[15:8]);
      host_write(9'h12A, p[23:16]);
   endtask

   initial begin
      RES = 1'b1;
      PIN_AB = 8'h00; PIN_AB09 = 1'b0; PIN_DB_IN = 8'h00;
      PIN_NCS = 1'b1; PIN_NRD = 1'b1; PIN_NWR = 1'b1;
      m_reset();
      repeat (3) @(negedge CLK);
      check("rst_db_out", {24'd0, PIN_DB_OUT}, 32'd0);
      check("rst_wait",   {31'd0, PIN_WAIT}, 32'd1);
      check("rst_strobes", {29'd0, PIN_RACS, PIN_RAWP, PIN_RAOE}, 32'd7);
      check("rst_ra",     {8'd0, PIN_RA}, 32'd0);
      check("rst_rd_out", {24'd0, PIN_RD_OUT}, 32'd0);
      RES = 1'b0;
      repeat (3) @(negedge CLK);

      // channel bank and bank select
      host_write(9'h050, 8'h11);
      host_write(9'h051, 8'h22);
      host_read(9'h050);
      host_read(9'h051);
      host_read(9'h150);
      host_read(9'h050);
      @(negedge CLK);
      check("db_out_ncs_high", {24'd0, PIN_DB_OUT}, 32'd0);

      // control bank storage and unmapped range
      host_write(9'h11B, 8'h10);
      host_write(9'h11C, 8'h15);
      host_write(9'h122, 8'h06);
      host_write(9'h123, 8'h13);
      host_write(9'h140, 8'h77);
      host_read(9'h11B); host_read(9'h11C); host_read(9'h122); host_read(9'h123);
      host_read(9'h140);

      // key on / off
      host_write(9'h114, 8'h05);
      host_write(9'h115, 8'h01);
      host_read(9'h12C);
      host_read(9'h114);
      host_read(9'h115);

      // RAM port write, pointer advance
      host_write(9'h12F, 8'h10);
      set_ptr(24'h000012);
      host_write(9'h12D, 8'hAB);
      host_read(9'h128);
      host_read(9'h129);

      // RAM port read with pointer wrap
      set_ptr(24'hFFFFFF);
      host_read(9'h12D);
      host_read(9'h128); host_read(9'h129); host_read(9'h12A);

      // port disabled: access ignored
      host_write(9'h12F, 8'h00);
      host_write(9'h12D, 8'h99);
      host_read(9'h12D);
      host_read(9'h128);
      host_write(9'h12F, 8'h10);

      // host write event while a port read is busy is dropped
      set_ptr(24'h000100);
      @(negedge CLK);
      PIN_AB = 8'h2D; PIN_AB09 = 1'b1; PIN_NCS = 1'b0; PIN_NRD = 1'b0;
      begin
         logic [7:0] v;
         m_read(9'h12D, v);
      end
      repeat (3) @(negedge CLK);
      PIN_AB = 8'h28; PIN_DB_IN = 8'h77; PIN_NWR = 1'b0;
      repeat (4) @(negedge CLK);
      wait_idle();
      PIN_NCS = 1'b1; PIN_NRD = 1'b1; PIN_NWR = 1'b1;
      repeat (3) @(negedge CLK);
      host_read(9'h128);

      // randomized traffic
      for (int n = 0; n < 160; n++) begin
         logic [8:0] a;
         logic [7:0] d;
         int op = int'($urandom_range(0, 5));
         d = 8'($urandom);
         case (op)
            0: host_write({1'b0, 8'($urandom)}, d);
            1: host_read({1'b0, 8'($urandom)});
            2: host_write({1'b1, 8'($urandom_range(0, 8'h3F))}, d);
            3: host_read({1'b1, 8'($urandom)});
            4: host_read({1'b1, 8'($urandom_range(8'h28, 8'h2F))});
            default: begin
               a = {1'b1, 8'($urandom_range(8'h28, 8'h2F))};
               host_write(a, d);
            end
         endcase
      end

      // reset during strobe aborts the access
      host_write(9'h12F, 8'h10);
      set_ptr(24'h000050);
      abort_exp = 1'b1;
      @(negedge CLK);
      PIN_AB = 8'h2D; PIN_AB09 = 1'b1; PIN_DB_IN = 8'h3C;
      PIN_NCS = 1'b0; PIN_NWR = 1'b0;
      begin
         int n = 0;
         while (PIN_RAWP && n < 20) begin
            @(negedge CLK);
            n++;
         end
         check("rawp_seen", {31'd0, PIN_RAWP}, 32'd0);
      end
      RES = 1'b1;
      @(negedge CLK);
      check("abort_racs", {31'd0, PIN_RACS}, 32'd1);
      check("abort_rawp", {31'd0, PIN_RAWP}, 32'd1);
      check("abort_wait", {31'd0, PIN_WAIT}, 32'd1);
      PIN_NCS = 1'b1; PIN_NWR = 1'b1;
      repeat (3) @(negedge CLK);
      RES = 1'b0;
      m_reset();
      repeat (2) @(negedge CLK);
      abort_exp = 1'b0;
      host_read(9'h128);
      host_read(9'h12F);
      host_read(9'h050);

      repeat (5) @(negedge CLK);
      check("q_rd_empty", q_rd.size(), 0);
      check("q_wr_empty", q_wr.size(), 0);
      check("q_rr_empty", q_rr.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
